// File: rtl/pc_pkg.sv
// Shared constants and types for the next-PC generator.
// Optional feature macro: PC_MISALIGN_TRAP_EN (adds the trap vector constant).
package pc_pkg;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
`endif

    // Major opcodes that redirect the PC
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Branch funct3 encodings (010/011 are reserved and never taken)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Select codes for the PC-source 4:1 mux
    localparam logic [1:0] PCS_PLUS4  = 2'd0;
    localparam logic [1:0] PCS_JALR   = 2'd1;
    localparam logic [1:0] PCS_BRANCH = 2'd2;
    localparam logic [1:0] PCS_JAL    = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/branch_cond_gen.sv
// Branch condition evaluator: compares rs1/rs2 as selected by funct3.
module branch_cond_gen
    import pc_pkg::*;
(
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  funct3,
    output logic        taken
);

    // Evaluate the comparison named by funct3
    always_comb begin
        // NOTE: default assignment first so no path leaves taken unassigned (no latch).
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_src_gen.sv
// Next-PC generator: owns PC and IR, runs the fetch/exec handshake and
// produces the candidate next-PC values plus the PC-source select.
// Optional feature macro: PC_MISALIGN_TRAP_EN (trap on misaligned target).
module pc_src_gen
    import pc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_ack,
    input  logic [31:0] instr,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        hold,
    output logic        fetch_req,
    output logic        exec_valid,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic [1:0]  pc_source,
    output logic [31:0] pc_plus4,
    output logic [31:0] jalr_tgt,
    output logic [31:0] branch_tgt,
    output logic [31:0] jal_tgt,
    output logic        misalign
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        fetch_req_q, exec_valid_q;
    logic        misalign_q, misalign_d;
    logic        branch_taken;
    logic [31:0] imm_i, imm_b, imm_j;
    logic [31:0] sel_tgt;

    // Immediate extraction from the held instruction
    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Candidate targets are live in every state; wrap-around is intentional
    assign pc_plus4   = pc_q + 32'd4;
    assign jalr_tgt   = (rs1 + imm_i) & ~32'h1;
    assign branch_tgt = pc_q + imm_b;
    assign jal_tgt    = pc_q + imm_j;

    branch_cond_gen u_branch_cond (
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (ir_q[14:12]),
        .taken  (branch_taken)
    );

    // Decode the PC source; held at PC+4 outside EXEC
    always_comb begin
        pc_source = PCS_PLUS4;
        if (state_q == ST_EXEC) begin
            case (ir_q[6:0])
                OP_JAL:    pc_source = PCS_JAL;
                OP_JALR:   pc_source = PCS_JALR;
                OP_BRANCH: pc_source = branch_taken ? PCS_BRANCH : PCS_PLUS4;
                default:   pc_source = PCS_PLUS4;
            endcase
        end
    end

    // PC-source 4:1 mux
    always_comb begin
        sel_tgt = pc_plus4;
        case (pc_source)
            PCS_JALR:   sel_tgt = jalr_tgt;
            PCS_BRANCH: sel_tgt = branch_tgt;
            PCS_JAL:    sel_tgt = jal_tgt;
            default:    sel_tgt = pc_plus4;
        endcase
    end

    // Next-state, PC, IR and misalign flag
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        misalign_d = misalign_q;
        case (state_q)
            ST_INIT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (fetch_ack) begin
                    ir_d    = instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!hold) begin
                    state_d = ST_FETCH;
`ifdef PC_MISALIGN_TRAP_EN
                    if (sel_tgt[1:0] != 2'b00) begin
                        pc_d       = TRAP_VEC;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = sel_tgt;
                    end
`else
                    pc_d = sel_tgt;
`endif
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            pc_q         <= RESET_VEC;
            ir_q         <= 32'h0;
            fetch_req_q  <= 1'b0;
            exec_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            fetch_req_q  <= (state_d == ST_FETCH);
            exec_valid_q <= (state_d == ST_EXEC);
            misalign_q   <= misalign_d;
        end
    end

    assign fetch_req  = fetch_req_q;
    assign exec_valid = exec_valid_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign   = misalign_q;
`else
    assign misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_src_gen.sv
// Self-checking bench for pc_src_gen with a behavioural next-PC model.
// Honours PC_MISALIGN_TRAP_EN when the design is built with it.
module tb_pc_src_gen;

    logic        clk;
    logic        rst_n;
    logic        fetch_ack;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        hold;
    logic        fetch_req;
    logic        exec_valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [1:0]  pc_source;
    logic [31:0] pc_plus4;
    logic [31:0] jalr_tgt;
    logic [31:0] branch_tgt;
    logic [31:0] jal_tgt;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_pc;
    logic        model_mis;

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] BEQ  = 32'h0020_8863;
    localparam logic [31:0] BLT  = 32'h0020_C863;
    localparam logic [31:0] BLTU = 32'h0020_E863;
    localparam logic [31:0] JALR = 32'h0032_8067;

    pc_src_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_ack  (fetch_ack),
        .instr      (instr),
        .rs1        (rs1),
        .rs2        (rs2),
        .hold       (hold),
        .fetch_req  (fetch_req),
        .exec_valid (exec_valid),
        .pc         (pc),
        .ir         (ir),
        .pc_source  (pc_source),
        .pc_plus4   (pc_plus4),
        .jalr_tgt   (jalr_tgt),
        .branch_tgt (branch_tgt),
        .jal_tgt    (jal_tgt),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Assemble "jal x1, imm"
    function automatic logic [31:0] enc_jal(input int imm);
        logic [31:0] t;
        t = imm;
        return {t[20], t[10:1], t[11], t[19:12], 5'd1, 7'h6F};
    endfunction

    // Architectural next-PC rules, written from the ISA description
    function automatic void ref_next(input logic [31:0] ins, input logic [31:0] cur,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [1:0] src, output logic [31:0] p4,
                                     output logic [31:0] jr, output logic [31:0] br,
                                     output logic [31:0] jl);
        logic [11:0] ii;
        logic [12:0] bi;
        logic [20:0] ji;
        logic        tk;
        ii = ins[31:20];
        bi = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ji = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        p4 = cur + 32'd4;
        jr = (a + 32'($signed(ii))) & 32'hFFFF_FFFE;
        br = cur + 32'($signed(bi));
        jl = cur + 32'($signed(ji));
        case (ins[14:12])
            3'd0:    tk = (a == b);
            3'd1:    tk = (a != b);
            3'd4:    tk = ($signed(a) < $signed(b));
            3'd5:    tk = ($signed(a) >= $signed(b));
            3'd6:    tk = (a < b);
            3'd7:    tk = (a >= b);
            default: tk = 1'b0;
        endcase
        case (ins[6:0])
            7'h6F:   src = 2'd3;
            7'h67:   src = 2'd1;
            7'h63:   src = tk ? 2'd2 : 2'd0;
            default: src = 2'd0;
        endcase
    endfunction

    // Release reset at a falling edge and check the INIT -> FETCH step
    task automatic do_release();
        rst_n = 1'b1;
        #1;
        total++;
        if (fetch_req !== 1'b0) begin
            bad++;
            $display("FAIL init_fetch_req got %0b want 0", fetch_req);
        end
        @(negedge clk);
        total++;
        if (fetch_req !== 1'b1 || exec_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_fetch_req got req=%0b ev=%0b want 1/0", fetch_req, exec_valid);
        end
        model_pc  = 32'h0;
        model_mis = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_ack = 1'b0; instr = 32'h0; rs1 = 32'h0; rs2 = 32'h0; hold = 1'b0;
        @(negedge clk);
        fetch_ack = 1'b1; instr = ADDI;
        @(negedge clk);
        total++;
        if (pc !== 32'h0 || ir !== 32'h0 || fetch_req !== 1'b0 || exec_valid !== 1'b0 ||
            misalign !== 1'b0 || pc_source !== 2'd0) begin
            bad++;
            $display("FAIL reset_values got pc=%h ir=%h req=%0b ev=%0b mis=%0b src=%0d",
                     pc, ir, fetch_req, exec_valid, misalign, pc_source);
        end
        fetch_ack = 1'b0;
        do_release();
    endtask

    // One full FETCH/EXEC transaction checked against the model
    task automatic run_instr(input string tag, input logic [31:0] ins,
                             input logic [31:0] a, input logic [31:0] b,
                             input int ack_dly, input int hold_n,
                             output logic [1:0] o_src, output logic [31:0] o_pc);
        logic [1:0]  e_src;
        logic [31:0] e_p4, e_jr, e_br, e_jl, e_tgt;
        total++;
        if (fetch_req !== 1'b1 || pc !== model_pc) begin
            bad++;
            $display("FAIL %s fetch_entry got req=%0b pc=%h want 1/%h", tag, fetch_req, pc, model_pc);
        end
        for (int i = 0; i < ack_dly; i++) begin
            fetch_ack = 1'b0; instr = $urandom; hold = 1'($urandom_range(0, 1));
            @(negedge clk);
            total++;
            if (fetch_req !== 1'b1 || exec_valid !== 1'b0 || pc_source !== 2'd0) begin
                bad++;
                $display("FAIL %s fetch_wait got req=%0b ev=%0b src=%0d", tag, fetch_req, exec_valid, pc_source);
            end
        end
        fetch_ack = 1'b1; instr = ins; hold = 1'($urandom_range(0, 1));
        @(negedge clk);
        fetch_ack = 1'($urandom_range(0, 1)); instr = $urandom; rs1 = a; rs2 = b;
        ref_next(ins, model_pc, a, b, e_src, e_p4, e_jr, e_br, e_jl);
        o_src = 2'd0;
        for (int h = 0; h <= hold_n; h++) begin
            hold = (h < hold_n);
            #1;
            total++;
            if (exec_valid !== 1'b1 || fetch_req !== 1'b0 || ir !== ins || pc !== model_pc) begin
                bad++;
                $display("FAIL %s exec_state got ev=%0b req=%0b ir=%h pc=%h want 1/0/%h/%h",
                         tag, exec_valid, fetch_req, ir, pc, ins, model_pc);
            end
            total++;
            if (pc_source !== e_src) begin
                bad++;
                $display("FAIL %s pc_source got %0d want %0d", tag, pc_source, e_src);
            end
            total++;
            if (pc_plus4 !== e_p4 || jalr_tgt !== e_jr || branch_tgt !== e_br || jal_tgt !== e_jl) begin
                bad++;
                $display("FAIL %s targets got %h %h %h %h want %h %h %h %h", tag,
                         pc_plus4, jalr_tgt, branch_tgt, jal_tgt, e_p4, e_jr, e_br, e_jl);
            end
            o_src = pc_source;
            @(negedge clk);
            fetch_ack = 1'($urandom_range(0, 1));
        end
        hold = 1'b0; fetch_ack = 1'b0;
        case (e_src)
            2'd1:    e_tgt = e_jr;
            2'd2:    e_tgt = e_br;
            2'd3:    e_tgt = e_jl;
            default: e_tgt = e_p4;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        if (e_tgt[1:0] != 2'b00) begin
            e_tgt     = 32'h0000_0100;
            model_mis = 1'b1;
        end
`endif
        model_pc = e_tgt;
        total++;
        if (fetch_req !== 1'b1 || exec_valid !== 1'b0 || pc !== model_pc || misalign !== model_mis) begin
            bad++;
            $display("FAIL %s next_pc got req=%0b ev=%0b pc=%h mis=%0b want 1/0/%h/%0b",
                     tag, fetch_req, exec_valid, pc, misalign, model_pc, model_mis);
        end
        o_pc = pc;
    endtask

    task automatic test_first_fetch();
        logic [1:0]  s;
        logic [31:0] p;
        run_instr("addi", ADDI, 32'h0, 32'h0, 0, 0, s, p);
        total++;
        if (s !== 2'd0 || p !== 32'h4) begin
            bad++;
            $display("FAIL addi_literal got src=%0d pc=%h want 0/00000004", s, p);
        end
    endtask

    task automatic test_branch();
        logic [1:0]  s;
        logic [31:0] p;
        run_instr("jal_to_40", enc_jal(32'h3C), 32'h0, 32'h0, 1, 0, s, p);
        run_instr("beq_taken", BEQ, 32'd7, 32'd7, 0, 0, s, p);
        total++;
        if (s !== 2'd2 || p !== 32'h50) begin
            bad++;
            $display("FAIL beq_taken_literal got src=%0d pc=%h want 2/00000050", s, p);
        end
        run_instr("jal_back", enc_jal(-16), 32'h0, 32'h0, 0, 0, s, p);
        run_instr("beq_not", BEQ, 32'd7, 32'd8, 0, 0, s, p);
        total++;
        if (s !== 2'd0 || p !== 32'h44) begin
            bad++;
            $display("FAIL beq_not_literal got src=%0d pc=%h want 0/00000044", s, p);
        end
        run_instr("blt", BLT, 32'hFFFF_FFFF, 32'h1, 0, 0, s, p);
        total++;
        if (s !== 2'd2) begin
            bad++;
            $display("FAIL blt_literal got src=%0d want 2", s);
        end
        run_instr("bltu", BLTU, 32'hFFFF_FFFF, 32'h1, 0, 0, s, p);
        total++;
        if (s !== 2'd0) begin
            bad++;
            $display("FAIL bltu_literal got src=%0d want 0", s);
        end
    endtask

    task automatic test_jalr();
        logic [1:0]  s;
        logic [31:0] p;
        run_instr("jalr", JALR, 32'h1000, 32'h0, 0, 0, s, p);
        total++;
`ifdef PC_MISALIGN_TRAP_EN
        if (s !== 2'd1 || p !== 32'h100 || misalign !== 1'b1) begin
            bad++;
            $display("FAIL jalr_literal got src=%0d pc=%h mis=%0b want 1/00000100/1", s, p, misalign);
        end
`else
        if (s !== 2'd1 || p !== 32'h1002 || misalign !== 1'b0) begin
            bad++;
            $display("FAIL jalr_literal got src=%0d pc=%h mis=%0b want 1/00001002/0", s, p, misalign);
        end
`endif
        run_instr("after_jalr", ADDI, 32'h0, 32'h0, 0, 1, s, p);
    endtask

    task automatic test_hold_reset();
        logic [31:0] p;
        p = pc;
        fetch_ack = 1'b1; instr = ADDI;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            hold = 1'b1; fetch_ack = (i != 1); instr = $urandom;
            @(negedge clk);
            total++;
            if (exec_valid !== 1'b1 || pc !== p || ir !== ADDI) begin
                bad++;
                $display("FAIL hold_cycle%0d got ev=%0b pc=%h ir=%h want 1/%h/%h", i, exec_valid, pc, ir, p, ADDI);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (pc !== 32'h0 || ir !== 32'h0 || exec_valid !== 1'b0 || fetch_req !== 1'b0 ||
            pc_source !== 2'd0 || misalign !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_exec got pc=%h ir=%h ev=%0b req=%0b src=%0d mis=%0b",
                     pc, ir, exec_valid, fetch_req, pc_source, misalign);
        end
        hold = 1'b0; fetch_ack = 1'b0;
        @(negedge clk);
        do_release();
    endtask

    task automatic test_jal_wrap();
        logic [1:0]  s;
        logic [31:0] p;
        run_instr("wrap_addi", ADDI, 32'h0, 32'h0, 0, 0, s, p);
        run_instr("jal_wrap", enc_jal(-8), 32'h0, 32'h0, 0, 0, s, p);
        total++;
        if (s !== 2'd3 || p !== 32'hFFFF_FFFC) begin
            bad++;
            $display("FAIL jal_wrap_literal got src=%0d pc=%h want 3/fffffffc", s, p);
        end
    endtask

    task automatic test_random();
        logic [1:0]  s;
        logic [31:0] p, ins, a, b;
        logic [6:0]  op;
        rst_n = 1'b0;
        @(negedge clk);
        do_release();
        for (int n = 0; n < 40; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 3))
                0:       op = 7'h6F;
                1:       op = 7'h67;
                2:       op = 7'h63;
                default: op = 7'h13;
            endcase
            ins[6:0] = op;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr("random", ins, a, b, $urandom_range(0, 2), $urandom_range(0, 2), s, p);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_branch();
        test_jalr();
        test_hold_reset();
        test_jal_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_src_gen.md
# pc_src_gen

Next-PC generator for the multicycle RV32 core. It owns the program counter and instruction register, and runs a fetch/execute handshake with instruction memory. During execute it decodes the instruction and produces the four candidate next-PC values plus the 2-bit pcSource select that feeds the PC-source 4:1 mux. It also loads the PC with the selected target.

## Interface
- RESET_VEC, 32'h0000_0000, PC value loaded at reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on misaligned target (only with PC_MISALIGN_TRAP_EN).
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- FETCH_ACK  in  1  memory has valid data on INSTR this cycle.
- INSTR  in  32  fetched instruction word.
- RS1, RS2  in  32 each  register-file read data for IR's rs1/rs2, valid in EXEC.
- HOLD  in  1  extends EXEC by one cycle per asserted cycle.
- FETCH_REQ  out  1  fetch request for address PC.
- EXEC_VALID  out  1  IR valid, core executing.
- PC  out  32  registered program counter.
- IR  out  32  registered instruction.
- PC_SOURCE  out  2  0 = PC+4, 1 = jalr, 2 = branch, 3 = jal.
- PC_PLUS4, JALR_TGT, BRANCH_TGT, JAL_TGT  out  32 each  candidate next-PC values.
- MISALIGN  out  1  sticky misaligned-target flag.

## Operation
- FSM states: INIT -> FETCH -> EXEC -> FETCH ...
  - INIT is the reset state and lasts exactly one cycle.
  - FETCH waits for FETCH_ACK, then latches IR <= INSTR and moves to EXEC.
  - EXEC with HOLD=1: stays in EXEC; PC and IR unchanged.
  - EXEC with HOLD=0: PC <= selected target, then goes to FETCH.
- FETCH_REQ = (state==FETCH). EXEC_VALID = (state==EXEC). FETCH_ACK is ignored outside FETCH.
- Targets are combinational from PC, IR, RS1 and are valid in every state. All arithmetic is 32-bit modulo, so wrap past 32'hFFFF_FFFC is silent.
  - PC_PLUS4 = PC+4.
  - JALR_TGT = (RS1 + sext I-imm) & ~32'h1.
  - BRANCH_TGT = PC + sext B-imm.
  - JAL_TGT = PC + sext J-imm.
- PC_SOURCE decode uses IR[6:0]:
  - 1101111 (jal) -> 3.
  - 1100111 (jalr) -> 1.
  - 1100011 (branch) -> 2 if the condition is true, else 0.
  - Any other opcode -> 0.
- Branch conditions by funct3:
  - 000 eq, 001 ne.
  - 100 signed lt, 101 signed ge.
  - 110 unsigned lt, 111 unsigned ge.
  - 010/011 are never taken.
- PC_SOURCE is meaningful only when EXEC_VALID=1. It is forced to 0 in other states.

## Timing
- Reset values:
  - state INIT.
  - PC = RESET_VEC, IR = 0.
  - FETCH_REQ = 0, EXEC_VALID = 0, MISALIGN = 0.
  - PC_SOURCE = 0.
- First cycle after RST_N rises: INIT. FETCH_REQ rises on the following edge.
- Minimum instruction period is 2 cycles (ACK in the first FETCH cycle, no HOLD).
- FETCH_ACK in the FETCH cycle: IR valid and EXEC_VALID=1 from the next edge.
- Last EXEC cycle: the new PC is visible and FETCH_REQ=1 from the next edge.
- HOLD is sampled only in EXEC. HOLD during FETCH has no effect.
- Reset asserted mid-FETCH or mid-EXEC: immediate return to reset values. No PC update occurs.

## Configuration
- PC_MISALIGN_TRAP_EN defined:
  - In the final EXEC cycle, if selected target[1:0] != 0, then PC <= TRAP_VEC and MISALIGN <= 1.
  - MISALIGN stays high until reset.
- PC_MISALIGN_TRAP_EN undefined: PC loads the target unchanged, MISALIGN is tied 0, and TRAP_VEC is unused.

## Structure
- Shared package (pc_pkg) holds:
  - opcode constants OP_JAL, OP_JALR, OP_BRANCH;
  - funct3 constants;
  - PC_SOURCE encodings PCS_PLUS4/PCS_JALR/PCS_BRANCH/PCS_JAL;
  - the state enum.
- One sub-module, branch_cond_gen: combinational, takes RS1, RS2, funct3 and returns taken.
- The FSM, PC/IR registers and immediate generation stay in pc_src_gen.

## Test plan
- Reset release, ACK in the first FETCH cycle with INSTR = addi (0x00500093):
  - FETCH_REQ rises 1 cycle after INIT; EXEC one cycle later with PC_SOURCE=0;
  - PC goes 0x0 -> 0x4.
- PC=0x40, beq x1,x2,+16 (0x00208863):
  - RS1=RS2=7 gives PC_SOURCE=2, PC -> 0x50;
  - RS1=7, RS2=8 gives PC_SOURCE=0, PC -> 0x44.
- blt vs bltu, RS1=0xFFFF_FFFF, RS2=1: blt taken, bltu not taken.
- jalr x0,3(x5) with RS1=0x1000 (0x00328067): JALR_TGT=0x1002, PC_SOURCE=1.
  - Macro on: PC -> TRAP_VEC, MISALIGN=1.
  - Macro off: PC -> 0x1002.
- EXEC held 3 cycles by HOLD, then reset asserted mid-EXEC: PC stays constant during HOLD, then returns to RESET_VEC; FETCH_ACK pulses in EXEC are ignored.
- jal -8 at PC=0x4: PC_SOURCE=3, PC -> 0xFFFF_FFFC (wrap).
